// File: rtl/goboard_move_arbiter.sv
// rtl/goboard_move_arbiter.sv - arbitrates keyboard/host Go moves onto a board RAM by turn.
// Optional feature: define GOBOARD_MOVE_CNT_EN to enable the saturating move counter on move_cnt.
module goboard_move_arbiter #(
    parameter int   BOARD_N   = 19,
    parameter logic KBD_COLOR = 1'b0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       kbd_set,
    input  logic [4:0] kbd_x,
    input  logic [4:0] kbd_y,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic [4:0] host_x,
    input  logic [4:0] host_y,
    output logic [8:0] brd_addr,
    input  logic [1:0] brd_rd_data,
    output logic       brd_we,
    output logic [1:0] brd_wr_data,
    output logic       turn,
    output logic       busy,
    output logic       move_done,
    output logic       move_err,
    output logic [1:0] err_code,
    output logic [8:0] move_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CHK  = 2'd2,
        WR   = 2'd3
    } state_t;

    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_OCC   = 2'd2;
    localparam logic [1:0] ERR_TURN  = 2'd3;

    state_t     state;
    state_t     state_next;
    logic       kbd_q;
    logic       armed;
    logic       kbd_edge;
    logic       kbd_turn;
    logic       host_fire;
    logic       accept;
    logic       in_range;
    logic       err_set;
    logic [1:0] err_set_code;
    logic [4:0] sel_x;
    logic [4:0] sel_y;
    logic [8:0] addr_calc;

    assign kbd_edge  = kbd_set & ~kbd_q;
    assign kbd_turn  = (turn == KBD_COLOR);
    // armed stays low for the first cycle after clr so the host never sees an early ready
    assign host_ready = (state == IDLE) && !kbd_turn && armed;
    assign host_fire  = host_valid && host_ready;

    assign sel_x     = kbd_turn ? kbd_x : host_x;
    assign sel_y     = kbd_turn ? kbd_y : host_y;
    assign in_range  = (int'(sel_x) < BOARD_N) && (int'(sel_y) < BOARD_N);
    assign addr_calc = sel_y * 9'(BOARD_N) + 9'(sel_x);

    assign busy        = (state != IDLE);
    assign brd_we      = (state == WR);
    assign brd_wr_data = (state == WR) ? ({1'b0, turn} + 2'd1) : 2'd0;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        err_set      = 1'b0;
        err_set_code = 2'd0;
        case (state)
            IDLE: begin
                if (kbd_turn) begin
                    accept = kbd_edge;
                end else begin
                    accept = host_fire;
                    if (kbd_edge) begin
                        err_set      = 1'b1;
                        err_set_code = ERR_TURN;
                    end
                end
                if (accept) begin
                    if (in_range) begin
                        state_next = RD;
                    end else begin
                        err_set      = 1'b1;
                        err_set_code = ERR_RANGE;
                    end
                end
            end
            RD: begin
                state_next = CHK;
            end
            CHK: begin
                if (brd_rd_data != 2'd0) begin
                    err_set      = 1'b1;
                    err_set_code = ERR_OCC;
                    state_next   = IDLE;
                end else begin
                    state_next = WR;
                end
            end
            WR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            kbd_q     <= 1'b0;
            armed     <= 1'b0;
            turn      <= 1'b0;
            brd_addr  <= 9'd0;
            move_done <= 1'b0;
            move_err  <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            kbd_q     <= kbd_set;
            armed     <= 1'b1;
            move_done <= (state == WR);
            move_err  <= err_set;
            if (err_set) begin
                err_code <= err_set_code;
            end
            if (state == WR) begin
                turn <= ~turn;
            end
            // address is captured once at accept and held through WR
            if (accept && in_range) begin
                brd_addr <= addr_calc;
            end
        end
    end

`ifdef GOBOARD_MOVE_CNT_EN
    logic [8:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= 9'd0;
        end else if ((state == WR) && (cnt_q != 9'd511)) begin
            cnt_q <= cnt_q + 9'd1;
        end
    end

    assign move_cnt = cnt_q;
`else
    assign move_cnt = 9'd0;
`endif

endmodule

// File: tb/tb_goboard_move_arbiter.sv
// tb/tb_goboard_move_arbiter.sv - directed self-checking bench for goboard_move_arbiter.
module tb_goboard_move_arbiter;

`ifdef GOBOARD_MOVE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic       kbd_set;
    logic [4:0] kbd_x;
    logic [4:0] kbd_y;
    logic       host_valid;
    logic       host_ready;
    logic [4:0] host_x;
    logic [4:0] host_y;
    logic [8:0] brd_addr;
    logic [1:0] brd_rd_data;
    logic       brd_we;
    logic [1:0] brd_wr_data;
    logic       turn;
    logic       busy;
    logic       move_done;
    logic       move_err;
    logic [1:0] err_code;
    logic [8:0] move_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    int         w_we_cnt;
    int         w_done_cnt;
    int         w_done_at;
    int         w_err_cnt;
    int         w_err_at;
    int         w_err_code;
    int         w_addr;
    int         w_data;
    int         w_both;
    logic [31:0] w_busy;

    logic [1:0] mem [0:511] = '{default: 2'd0};
    logic [1:0] rd_q = 2'd0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (brd_we) mem[brd_addr] <= brd_wr_data;
        rd_q <= mem[brd_addr];
    end
    assign brd_rd_data = rd_q;

    goboard_move_arbiter #(.BOARD_N(19), .KBD_COLOR(1'b0)) dut (
        .clk(clk), .clr(clr), .kbd_set(kbd_set), .kbd_x(kbd_x), .kbd_y(kbd_y),
        .host_valid(host_valid), .host_ready(host_ready), .host_x(host_x), .host_y(host_y),
        .brd_addr(brd_addr), .brd_rd_data(brd_rd_data), .brd_we(brd_we), .brd_wr_data(brd_wr_data),
        .turn(turn), .busy(busy), .move_done(move_done), .move_err(move_err),
        .err_code(err_code), .move_cnt(move_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles recording DUT activity; poke re-triggers kbd_set while busy.
    task automatic watch(input int n, input bit poke);
        w_we_cnt = 0; w_done_cnt = 0; w_done_at = -1; w_err_cnt = 0; w_err_at = -1;
        w_err_code = 0; w_addr = -1; w_data = -1; w_both = 0; w_busy = '0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (i == 1) host_valid = 1'b0;
            if (poke && i == 1) kbd_set = 1'b0;
            if (poke && i == 2) begin kbd_set = 1'b1; kbd_x = 5'd2; kbd_y = 5'd2; end
            if (brd_we) begin w_we_cnt++; w_addr = int'(brd_addr); w_data = int'(brd_wr_data); end
            if (move_done) begin w_done_cnt++; if (w_done_at < 0) w_done_at = i; end
            if (move_err) begin w_err_cnt++; if (w_err_at < 0) w_err_at = i; w_err_code = int'(err_code); end
            if (move_done && move_err) w_both++;
            if (i < 32) w_busy[i] = busy;
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; kbd_set = 1'b0; kbd_x = 5'd7; kbd_y = 5'd9;
        host_valid = 1'b0; host_x = 5'd1; host_y = 5'd1;
        tick(); tick(); tick();
        clr = 1'b0;
        n_checks++; if (turn !== 1'b0) $display("FAIL reset_turn got %0d want 0", turn); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0d want 0", busy); else n_pass++;
        n_checks++; if ({brd_we, brd_wr_data} !== 3'd0) $display("FAIL reset_we got %0d/%0d want 0/0", brd_we, brd_wr_data); else n_pass++;
        n_checks++; if (brd_addr !== 9'd0) $display("FAIL reset_addr got %0d want 0", brd_addr); else n_pass++;
        n_checks++; if ({move_done, move_err, err_code} !== 4'd0) $display("FAIL reset_flags got %0d/%0d/%0d want 0/0/0", move_done, move_err, err_code); else n_pass++;
        n_checks++; if (move_cnt !== 9'd0) $display("FAIL reset_cnt got %0d want 0", move_cnt); else n_pass++;
        n_checks++; if (host_ready !== 1'b0) $display("FAIL reset_host_ready got %0d want 0", host_ready); else n_pass++;
    endtask

    task automatic test_kbd_move();
        kbd_x = 5'd3; kbd_y = 5'd4; kbd_set = 1'b1;
        watch(8, 1'b0);
        n_checks++; if (w_done_at !== 4 || w_done_cnt !== 1) $display("FAIL kbd_done_at got %0d (n=%0d) want 4 (n=1)", w_done_at, w_done_cnt); else n_pass++;
        n_checks++; if (w_we_cnt !== 1 || w_addr !== 79 || w_data !== 1) $display("FAIL kbd_write got n=%0d a=%0d d=%0d want n=1 a=79 d=1", w_we_cnt, w_addr, w_data); else n_pass++;
        n_checks++; if (w_busy[4:1] !== 4'b0111) $display("FAIL kbd_busy got %b want 0111", w_busy[4:1]); else n_pass++;
        n_checks++; if (turn !== 1'b1 || w_err_cnt !== 0) $display("FAIL kbd_turn got turn=%0d errs=%0d want 1/0", turn, w_err_cnt); else n_pass++;
        n_checks++; if (move_cnt !== (CNT_EN ? 9'd1 : 9'd0)) $display("FAIL kbd_cnt got %0d want %0d", move_cnt, CNT_EN ? 1 : 0); else n_pass++;
        kbd_set = 1'b0;
        tick();
    endtask

    task automatic test_host_move();
        n_checks++; if (host_ready !== 1'b1) $display("FAIL host_ready_idle got %0d want 1", host_ready); else n_pass++;
        host_x = 5'd18; host_y = 5'd18; host_valid = 1'b1;
        watch(8, 1'b0);
        n_checks++; if (w_done_at !== 4 || w_done_cnt !== 1) $display("FAIL host_done_at got %0d (n=%0d) want 4 (n=1)", w_done_at, w_done_cnt); else n_pass++;
        n_checks++; if (w_we_cnt !== 1 || w_addr !== 360 || w_data !== 2) $display("FAIL host_write got n=%0d a=%0d d=%0d want n=1 a=360 d=2", w_we_cnt, w_addr, w_data); else n_pass++;
        n_checks++; if (turn !== 1'b0 || w_both !== 0) $display("FAIL host_turn got turn=%0d both=%0d want 0/0", turn, w_both); else n_pass++;
        n_checks++; if (move_cnt !== (CNT_EN ? 9'd2 : 9'd0)) $display("FAIL host_cnt got %0d want %0d", move_cnt, CNT_EN ? 2 : 0); else n_pass++;
    endtask

    task automatic test_occupied();
        kbd_x = 5'd0; kbd_y = 5'd0; kbd_set = 1'b1;
        watch(6, 1'b0);
        kbd_set = 1'b0;
        n_checks++; if (w_we_cnt !== 1 || w_addr !== 0 || turn !== 1'b1) $display("FAIL occ_setup got n=%0d a=%0d turn=%0d want 1/0/1", w_we_cnt, w_addr, turn); else n_pass++;
        host_x = 5'd3; host_y = 5'd4; host_valid = 1'b1;
        watch(6, 1'b0);
        n_checks++; if (w_err_cnt !== 1 || w_err_at !== 3 || w_err_code !== 2) $display("FAIL occ_err got n=%0d at=%0d code=%0d want 1/3/2", w_err_cnt, w_err_at, w_err_code); else n_pass++;
        n_checks++; if (w_we_cnt !== 0 || w_done_cnt !== 0 || turn !== 1'b1) $display("FAIL occ_nowrite got we=%0d done=%0d turn=%0d want 0/0/1", w_we_cnt, w_done_cnt, turn); else n_pass++;
    endtask

    task automatic test_range_and_turn();
        kbd_x = 5'd1; kbd_y = 5'd2; kbd_set = 1'b1;
        watch(4, 1'b0);
        n_checks++; if (w_err_cnt !== 1 || w_err_at !== 1 || w_err_code !== 3) $display("FAIL turn_err got n=%0d at=%0d code=%0d want 1/1/3", w_err_cnt, w_err_at, w_err_code); else n_pass++;
        n_checks++; if (w_busy[4:1] !== 4'b0000 || turn !== 1'b1 || err_code !== 2'd3) $display("FAIL turn_state got busy=%b turn=%0d code=%0d want 0000/1/3", w_busy[4:1], turn, err_code); else n_pass++;
        kbd_set = 1'b0;
        tick();
        host_x = 5'd5; host_y = 5'd5; host_valid = 1'b1;
        watch(6, 1'b0);
        n_checks++; if (w_addr !== 100 || turn !== 1'b0) $display("FAIL range_setup got a=%0d turn=%0d want 100/0", w_addr, turn); else n_pass++;
        kbd_x = 5'd19; kbd_y = 5'd0; kbd_set = 1'b1;
        watch(4, 1'b0);
        n_checks++; if (w_err_cnt !== 1 || w_err_at !== 1 || w_err_code !== 1) $display("FAIL range_err got n=%0d at=%0d code=%0d want 1/1/1", w_err_cnt, w_err_at, w_err_code); else n_pass++;
        n_checks++; if (w_busy[4:1] !== 4'b0000 || w_we_cnt !== 0 || brd_addr !== 9'd100) $display("FAIL range_noaccess got busy=%b we=%0d a=%0d want 0000/0/100", w_busy[4:1], w_we_cnt, brd_addr); else n_pass++;
        kbd_set = 1'b0;
        tick();
    endtask

    task automatic test_busy_drop();
        kbd_x = 5'd1; kbd_y = 5'd1; kbd_set = 1'b1;
        watch(10, 1'b1);
        n_checks++; if (w_done_cnt !== 1 || w_done_at !== 4) $display("FAIL drop_done got n=%0d at=%0d want 1/4", w_done_cnt, w_done_at); else n_pass++;
        n_checks++; if (w_we_cnt !== 1 || w_addr !== 20 || w_err_cnt !== 0) $display("FAIL drop_write got we=%0d a=%0d errs=%0d want 1/20/0", w_we_cnt, w_addr, w_err_cnt); else n_pass++;
        kbd_set = 1'b0;
        tick();
    endtask

    task automatic test_clr_abort();
        int we_seen;
        we_seen = 0;
        host_x = 5'd7; host_y = 5'd7; host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL abort_busy_chk got %0d want 1", busy); else n_pass++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++; if ({turn, busy, brd_we, brd_wr_data} !== 5'd0) $display("FAIL abort_core got t=%0d b=%0d we=%0d d=%0d want 0", turn, busy, brd_we, brd_wr_data); else n_pass++;
        n_checks++; if (brd_addr !== 9'd0 || move_cnt !== 9'd0 || host_ready !== 1'b0) $display("FAIL abort_regs got a=%0d c=%0d r=%0d want 0/0/0", brd_addr, move_cnt, host_ready); else n_pass++;
        n_checks++; if ({move_done, move_err, err_code} !== 4'd0) $display("FAIL abort_flags got %0d/%0d/%0d want 0/0/0", move_done, move_err, err_code); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (brd_we || move_done) we_seen++;
            tick();
        end
        n_checks++; if (we_seen !== 0 || mem[140] !== 2'd0) $display("FAIL abort_nowrite got ev=%0d cell=%0d want 0/0", we_seen, mem[140]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_kbd_move();
        test_host_move();
        test_occupied();
        test_range_and_turn();
        test_busy_drop();
        test_clr_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/goboard_move_arbiter.md
GOBOARD_MOVE_ARBITER -- requirements
Module: goboard_move_arbiter

Interface
REQ-001 SHALL have parameter BOARD_N, default 19, board side length; the legal coordinate range is 0..BOARD_N-1.
REQ-002 SHALL have parameter KBD_COLOR, default 0; the colour owned by the keyboard (0 black, 1 white); the host owns the other colour.
REQ-003 SHALL have port clk  in  1  sole clock, all logic on the rising edge.
REQ-004 SHALL have port clr  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port kbd_set  in  1  level from the keyboard entry block; a rising edge is a move request.
REQ-006 SHALL have ports kbd_x and kbd_y  in  5 each  keyboard coordinates, sampled on the kbd_set rising edge.
REQ-007 SHALL have ports host_valid in 1, host_ready out 1, and host_x and host_y in 5 each  host move request with valid/ready handshake.
REQ-008 SHALL have ports brd_addr out 9, brd_rd_data in 2, brd_we out 1, brd_wr_data out 2  board RAM port; read latency is 1 cycle; cell codes are 0 empty, 1 black, 2 white.
REQ-009 SHALL have ports turn out 1, busy out 1, move_done out 1 (pulse), move_err out 1 (pulse), err_code out 2, move_cnt out 9.

Function
REQ-010 SHALL implement the FSM IDLE -> RD -> CHK -> WR -> IDLE, with CHK -> IDLE on an occupied cell.
REQ-011 SHALL detect the kbd_set rising edge from a registered copy; in IDLE with turn==KBD_COLOR it SHALL latch kbd_x/kbd_y and leave IDLE.
REQ-012 SHALL assert host_ready only in IDLE with turn!=KBD_COLOR; the host transfer completes on a cycle with host_valid&&host_ready, which latches host_x/host_y.
REQ-013 SHALL, on a keyboard edge in IDLE when turn!=KBD_COLOR, pulse move_err for one cycle with err_code=3 (wrong turn) and change no other state.
REQ-014 SHALL range-check the latched coordinates in the accept cycle; if x>=BOARD_N or y>=BOARD_N it SHALL pulse move_err next cycle with err_code=1, stay in IDLE, and issue no RAM access.
REQ-015 SHALL, in RD, drive brd_addr=y*BOARD_N+x (9-bit, zero-extended) and hold brd_addr constant through WR.
REQ-016 SHALL, in CHK, pulse move_err with err_code=2 if brd_rd_data!=0, and return to IDLE without a write.
REQ-017 SHALL, in WR, assert brd_we for exactly one cycle with brd_wr_data=turn+1.
REQ-018 SHALL, in the cycle after WR, pulse move_done, toggle turn, and return to IDLE; accept-to-move_done latency is 4 cycles.
REQ-019 SHALL hold busy=1 in RD, CHK and WR, and busy=0 in IDLE.
REQ-020 SHALL silently drop keyboard edges that arrive while busy, with no error and no queuing.
REQ-021 SHALL let only the on-turn requester proceed, so simultaneous keyboard and host requests never conflict; the off-turn host stalls on host_ready=0.
REQ-022 SHALL never assert move_done and move_err in the same cycle.
REQ-023 SHALL leave err_code holding its last value between error pulses.

Reset
REQ-024 SHALL, on clr=1, put the FSM in IDLE and set turn=0, busy=0, brd_we=0, brd_wr_data=0, brd_addr=0, move_done=0, move_err=0, err_code=0, move_cnt=0, host_ready=0 and the edge register=0.
REQ-025 SHALL treat clr mid-move as an abort with no brd_we and no move_done, and clr SHALL take priority over all other events.
REQ-026 SHALL keep host_ready low in the first cycle after clr deasserts.

Configuration
REQ-027 SHALL, when the macro GOBOARD_MOVE_CNT_EN is defined, increment move_cnt on each move_done and saturate it at 511.
REQ-028 SHALL, when GOBOARD_MOVE_CNT_EN is undefined, keep the move_cnt port present and tie it to 0, with no counter register.

Verification
REQ-029 SHALL cover: KBD_COLOR=0 after reset, kbd_x=3, kbd_y=4, rising edge, RAM cell empty -> brd_addr=79, brd_we for one cycle with brd_wr_data=1, move_done 4 cycles after the edge, turn=1.
REQ-030 SHALL cover: turn=1, host_valid with host_x=18, host_y=18 -> handshake completes, brd_addr=360, brd_wr_data=2, turn=0; with the macro defined, move_cnt=2.
REQ-031 SHALL cover: host move to a cell whose brd_rd_data=1 -> move_err with err_code=2, no brd_we, turn unchanged.
REQ-032 SHALL cover: keyboard edge with kbd_x=19 -> move_err with err_code=1, no RAM access; a keyboard edge while turn=1 -> err_code=3.
REQ-033 SHALL cover: clr asserted in CHK -> no write; the next cycle shows all outputs at reset values, turn=0.
REQ-034 SHALL cover: keyboard edge while busy -> ignored, with exactly one move_done for the first request.
